// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin GNT# rotation with parking, a mandatory
// all-idle gap cycle between owners, and revocation of grants that are never used.
module pci_bus_arbiter #(
    parameter int N_DEV    = 4,
    parameter int TIMEOUT  = 16,
    parameter int PARK_EN  = 1,
    parameter int PARK_DEV = 0,
    localparam int OW      = $clog2(N_DEV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_DEV-1:0] req_n,
    input  logic             frame_n,
    input  logic             irdy_n,
    output logic [N_DEV-1:0] gnt_n,
    output logic [OW-1:0]    owner,
    output logic             owner_valid,
    output logic [1:0]       arb_state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_GAP   = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [N_DEV-1:0] gnt_n_q, gnt_n_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [7:0]       timer_q, timer_d;

    logic             bus_idle;
    logic             any_req;
    logic             others_req;
    logic             owner_req;
    logic             parked;
    logic [OW-1:0]    winner;
    logic [OW-1:0]    park_idx;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        if (int'(idx) == N_DEV - 1) begin
            return '0;
        end
        return idx + OW'(1);
    endfunction

    function automatic logic [N_DEV-1:0] grant_vec(input logic [OW-1:0] idx);
        logic [N_DEV-1:0] v;
        v      = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    assign bus_idle  = frame_n & irdy_n;
    assign owner_req = ~req_n[owner_q];
    assign park_idx  = OW'(PARK_DEV);
    // The bus is parked only while idle with a live grant; any other IDLE grant state is all-ones.
    assign parked    = (state_q == ST_IDLE) && owner_valid_q;

    // Round-robin search starting at ptr, wrapping modulo N_DEV.
    always_comb begin
        int idx;
        idx     = 0;
        winner  = ptr_q;
        any_req = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            idx = (int'(ptr_q) + i) % N_DEV;
            if (!any_req && !req_n[idx]) begin
                winner  = OW'(idx);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        others_req = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if (!req_n[i] && (i != int'(owner_q))) begin
                others_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_n_d       = gnt_n_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (parked && !frame_n) begin
                    // Parked master started a cycle on its own.
                    state_d = ST_BUSY;
                    timer_d = '0;
                end else if (any_req) begin
                    if (parked && (winner == owner_q)) begin
                        state_d = ST_GRANT;
                        timer_d = '0;
                    end else if (parked) begin
                        gnt_n_d       = '1;
                        owner_valid_d = 1'b0;
                        state_d       = ST_GAP;
                    end else begin
                        gnt_n_d       = grant_vec(winner);
                        owner_d       = winner;
                        owner_valid_d = 1'b1;
                        state_d       = ST_GRANT;
                        timer_d       = '0;
                    end
                end else if (PARK_EN != 0) begin
                    gnt_n_d       = grant_vec(park_idx);
                    owner_d       = park_idx;
                    owner_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!frame_n) begin
                    state_d = ST_BUSY;
                    ptr_d   = wrap_inc(owner_q);
                    timer_d = '0;
                end else if (!owner_req) begin
                    gnt_n_d       = '1;
                    owner_valid_d = 1'b0;
                    state_d       = ST_GAP;
                    timer_d       = '0;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    gnt_n_d       = '1;
                    owner_valid_d = 1'b0;
                    state_d       = ST_GAP;
                    ptr_d         = wrap_inc(owner_q);
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_BUSY: begin
                if (bus_idle) begin
                    gnt_n_d       = '1;
                    owner_valid_d = 1'b0;
                    state_d       = ST_GAP;
                end else if (others_req) begin
                    // Owner may only finish the cycle already in flight.
                    gnt_n_d       = '1;
                    owner_valid_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (any_req) begin
                    gnt_n_d       = grant_vec(winner);
                    owner_d       = winner;
                    owner_valid_d = 1'b1;
                    state_d       = ST_GRANT;
                    timer_d       = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_n_d       = '1;
                owner_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            gnt_n_q       <= '1;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ptr_q         <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_n_q       <= gnt_n_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
        end
    end

    assign gnt_n       = gnt_n_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign arb_state   = state_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: one non-parking and one parking instance, expected
// {gnt_n, owner, owner_valid, arb_state} queued per edge and compared after it.
module tb_pci_bus_arbiter;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_GRANT = 2'b01;
    localparam logic [1:0] S_BUSY  = 2'b10;
    localparam logic [1:0] S_GAP   = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic       frame_a, frame_b, irdy_a, irdy_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] owner_a, owner_b;
    logic       valid_a, valid_b;
    logic [1:0] state_a, state_b;

    logic [8:0] exp_q[$];
    bit         sel_q[$];
    string      tag_q[$];

    int         n_tests;
    int         n_fail;

    logic [8:0] mon_exp, mon_got;
    bit         mon_sel;
    string      mon_tag;
    logic [3:0] g_tmp;
    int         nx;

    pci_bus_arbiter #(.N_DEV(4), .TIMEOUT(16), .PARK_EN(0), .PARK_DEV(0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (req_a),
        .frame_n    (frame_a),
        .irdy_n     (irdy_a),
        .gnt_n      (gnt_a),
        .owner      (owner_a),
        .owner_valid(valid_a),
        .arb_state  (state_a)
    );

    pci_bus_arbiter #(.N_DEV(4), .TIMEOUT(16), .PARK_EN(1), .PARK_DEV(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_n      (req_b),
        .frame_n    (frame_b),
        .irdy_n     (irdy_b),
        .gnt_n      (gnt_b),
        .owner      (owner_b),
        .owner_valid(valid_b),
        .arb_state  (state_b)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] req, input logic fr, input logic ir);
        req_a   = req;
        frame_a = fr;
        irdy_a  = ir;
    endtask

    task automatic drive_b(input logic [3:0] req, input logic fr, input logic ir);
        req_b   = req;
        frame_b = fr;
        irdy_b  = ir;
    endtask

    // Queue the expected outputs for the coming edge, then advance to the next negedge.
    task automatic expect_step(input bit s, input logic [3:0] g, input logic [1:0] o,
                               input logic v, input logic [1:0] st, input string tag);
        exp_q.push_back({g, o, v, st});
        sel_q.push_back(s);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Scoreboard: one expectation consumed per rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_sel = sel_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_got = mon_sel ? {gnt_b, owner_b, valid_b, state_b}
                              : {gnt_a, owner_a, valid_a, state_a};
            check_eq(mon_tag, 16'(mon_got), 16'(mon_exp));
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive_a(4'b0000, 1'b1, 1'b1);
        drive_b(4'b0000, 1'b1, 1'b1);

        // T1 reset with every request asserted
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_IDLE, "t1_rst_a");
        expect_step(1, 4'b1111, 2'd0, 1'b0, S_IDLE, "t1_rst_b");
        rst_n = 1'b1;
        drive_a(4'b1111, 1'b1, 1'b1);
        drive_b(4'b1111, 1'b1, 1'b1);
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_IDLE, "park_first_edge");
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_IDLE, "idle_no_park");

        // T2 single requester, then re-request wins again after one gap
        drive_a(4'b1011, 1'b1, 1'b1);
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_GRANT, "t2_grant");
        drive_a(4'b1011, 1'b0, 1'b1);
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_BUSY, "t2_busy1");
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_BUSY, "t2_busy2");
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_BUSY, "t2_busy3");
        drive_a(4'b1011, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd2, 1'b0, S_GAP, "t2_gap");
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_GRANT, "t2_regrant");
        drive_a(4'b1111, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd2, 1'b0, S_GAP, "t2_withdraw");
        expect_step(0, 4'b1111, 2'd2, 1'b0, S_IDLE, "t2_idle");

        // Reset again with requests pending: pointer returns to 0
        rst_n = 1'b0;
        drive_a(4'b0000, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_IDLE, "rst_mid");
        rst_n = 1'b1;

        // T3 round robin with every master requesting
        expect_step(0, 4'b1110, 2'd0, 1'b1, S_GRANT, "t3_first");
        for (int m = 0; m < 4; m++) begin
            g_tmp    = 4'b1111;
            g_tmp[m] = 1'b0;
            nx       = (m + 1) % 4;
            drive_a(4'b0000, 1'b0, 1'b1);
            expect_step(0, g_tmp, 2'(m), 1'b1, S_BUSY, "t3_busy");
            expect_step(0, 4'b1111, 2'(m), 1'b0, S_BUSY, "t3_preempt");
            expect_step(0, 4'b1111, 2'(m), 1'b0, S_BUSY, "t3_busy_tail");
            drive_a(4'b0000, 1'b1, 1'b1);
            expect_step(0, 4'b1111, 2'(m), 1'b0, S_GAP, "t3_gap");
            g_tmp     = 4'b1111;
            g_tmp[nx] = 1'b0;
            expect_step(0, g_tmp, 2'(nx), 1'b1, S_GRANT, "t3_next");
        end
        drive_a(4'b1111, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_GAP, "t3_withdraw");
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_IDLE, "t3_idle");

        // T4 timeout: dev1 never starts a cycle, dev2 takes over
        drive_a(4'b1001, 1'b1, 1'b1);
        expect_step(0, 4'b1101, 2'd1, 1'b1, S_GRANT, "t4_grant");
        for (int k = 1; k < 16; k++) begin
            expect_step(0, 4'b1101, 2'd1, 1'b1, S_GRANT, "t4_hold");
        end
        expect_step(0, 4'b1111, 2'd1, 1'b0, S_GAP, "t4_revoke");
        expect_step(0, 4'b1011, 2'd2, 1'b1, S_GRANT, "t4_dev2");
        drive_a(4'b1111, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd2, 1'b0, S_GAP, "t4_withdraw");
        expect_step(0, 4'b1111, 2'd2, 1'b0, S_IDLE, "t4_idle");

        // T6 preemption of a busy owner
        drive_a(4'b1110, 1'b1, 1'b1);
        expect_step(0, 4'b1110, 2'd0, 1'b1, S_GRANT, "t6_grant0");
        drive_a(4'b1110, 1'b0, 1'b1);
        expect_step(0, 4'b1110, 2'd0, 1'b1, S_BUSY, "t6_busy");
        drive_a(4'b1100, 1'b0, 1'b1);
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_BUSY, "t6_revoke");
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_BUSY, "t6_wait_frame");
        drive_a(4'b1100, 1'b1, 1'b0);
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_BUSY, "t6_wait_irdy");
        drive_a(4'b1101, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd0, 1'b0, S_GAP, "t6_gap");
        expect_step(0, 4'b1101, 2'd1, 1'b1, S_GRANT, "t6_dev1");

        // FRAME# arriving on the timeout cycle wins over the revoke
        for (int k = 1; k < 16; k++) begin
            expect_step(0, 4'b1101, 2'd1, 1'b1, S_GRANT, "tcol_hold");
        end
        drive_a(4'b1101, 1'b0, 1'b1);
        expect_step(0, 4'b1101, 2'd1, 1'b1, S_BUSY, "tcol_frame_wins");
        drive_a(4'b1111, 1'b1, 1'b1);
        expect_step(0, 4'b1111, 2'd1, 1'b0, S_GAP, "tcol_gap");
        expect_step(0, 4'b1111, 2'd1, 1'b0, S_IDLE, "tcol_idle");

        // T5 parking instance
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_IDLE, "t5_parked");
        drive_b(4'b0111, 1'b1, 1'b1);
        expect_step(1, 4'b1111, 2'd0, 1'b0, S_GAP, "t5_unpark");
        expect_step(1, 4'b0111, 2'd3, 1'b1, S_GRANT, "t5_dev3");
        drive_b(4'b1111, 1'b1, 1'b1);
        expect_step(1, 4'b1111, 2'd3, 1'b0, S_GAP, "t5_withdraw");
        expect_step(1, 4'b1111, 2'd3, 1'b0, S_IDLE, "t5_idle");
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_IDLE, "t5_repark");
        drive_b(4'b1111, 1'b0, 1'b1);
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_BUSY, "t5_park_busy");
        drive_b(4'b1111, 1'b1, 1'b1);
        expect_step(1, 4'b1111, 2'd0, 1'b0, S_GAP, "t5_park_gap");
        expect_step(1, 4'b1111, 2'd0, 1'b0, S_IDLE, "t5_park_idle");
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_IDLE, "t5_park_again");
        drive_b(4'b1110, 1'b1, 1'b1);
        expect_step(1, 4'b1110, 2'd0, 1'b1, S_GRANT, "t5_parked_wins");
        drive_b(4'b1111, 1'b1, 1'b1);
        expect_step(1, 4'b1111, 2'd0, 1'b0, S_GAP, "t5_final_gap");

        @(negedge clk);
        check_eq("drain", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
